dot_accumulator: RTL



---
 rtl/dot_accumulator_if.sv | 14 +
 rtl/dot_accumulator.sv | 70 +++++++
 2 files changed

// File: rtl/dot_accumulator_if.sv
// dot_accumulator_if: start, product-in and result-out handshake bundle for the dot accumulator
interface dot_accumulator_if #(parameter int size = 16);
  logic            start;
  logic            in_valid;
  logic [size-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [size-1:0] out_data;
  logic            ovf;
  logic            busy;
  modport master (output start, in_valid, in_data, out_ready, input in_ready, out_valid, out_data, ovf, busy);
  modport slave  (input start, in_valid, in_data, out_ready, output in_ready, out_valid, out_data, ovf, busy);
endinterface

// File: rtl/dot_accumulator.sv
// dot_accumulator: sums len signed Q1.(size-1) products with guard bits, saturates and hands out one result
module dot_accumulator #(
  parameter int size  = 16,
  parameter int len   = 8,
  parameter int guard = 4
) (
  input logic clk,
  input logic rst,
  dot_accumulator_if.slave bus
);
  localparam int aw = size + guard;
  localparam int cw = $clog2(len) + 1;
  localparam logic signed [aw-1:0] max_v = {{(guard+1){1'b0}}, {(size-1){1'b1}}};
  localparam logic signed [aw-1:0] min_v = {{(guard+1){1'b1}}, {(size-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state_q, state_d;
  logic signed [aw-1:0] acc_q, acc_d, term, sum;
  logic [cw-1:0] count_q, count_d;
  logic [size-1:0] out_data_q, out_data_d;
  logic ovf_q, ovf_d;
  assign term = {{guard{bus.in_data[size-1]}}, bus.in_data};
  assign sum = acc_q + term;
  assign bus.in_ready = state_q == ACC;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy = state_q != IDLE;
  assign bus.out_data = out_data_q;
  assign bus.ovf = ovf_q;
  // next state: start in IDLE, accumulate accepted terms, saturate on the last one, wait for out_ready
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    count_d = count_q;
    out_data_d = out_data_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (bus.start) begin
        acc_d = '0;
        count_d = '0;
        state_d = ACC;
      end
      ACC: if (bus.in_valid) begin
        acc_d = sum;
        count_d = count_q + 1'b1;
        if (count_q == cw'(len - 1)) begin
          out_data_d = sum > max_v ? max_v[size-1:0] : sum < min_v ? min_v[size-1:0] : sum[size-1:0];
          ovf_d = (sum > max_v) || (sum < min_v);
          state_d = DONE;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any accumulation or pending result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      count_q <= '0;
      out_data_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      count_q <= count_d;
      out_data_q <= out_data_d;
      ovf_q <= ovf_d;
    end
  end
endmodule
